checkpoint_rollback_ctrl: RTL and testbench

- Sequences architectural-state checkpointing and rollback for the fault-tolerant core.
- During normal run, every CKPT_INTERVAL retired instructions it stalls the CPU and copies the register file and PC into an internal double-buffered shadow store.
- When the recovery FSM signals recover_cpu, it writes the last committed checkpoint back into the register file, presents the restore PC, and returns recovery_done.
- It escalates to a sticky failure after repeated rollbacks that have no intervening checkpoint.

---
 rtl/checkpoint_rollback_ctrl.sv | 161 ++++++++++++++++
 tb/tb_checkpoint_rollback_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/checkpoint_rollback_ctrl.sv
// Checkpoint/rollback sequencer: periodically snapshots the register file and PC into a
// double-buffered shadow store, and replays the last committed snapshot on recovery.
module checkpoint_rollback_ctrl #(
    parameter int                NUM_REGS      = 32,
    parameter int                ADDR_W        = 5,
    parameter int                DATA_W        = 32,
    parameter int                CKPT_INTERVAL = 64,
    parameter int                MAX_RETRY     = 3,
    parameter logic [DATA_W-1:0] RESET_PC      = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              freeze_cpu,
    input  logic              recover_cpu,
    input  logic              resume_cpu,
    input  logic              instr_retire,
    input  logic [DATA_W-1:0] pc_in,
    output logic [ADDR_W-1:0] rf_rd_addr,
    input  logic [DATA_W-1:0] rf_rd_data,
    output logic              rf_wr_en,
    output logic [ADDR_W-1:0] rf_wr_addr,
    output logic [DATA_W-1:0] rf_wr_data,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] pc_restore,
    output logic              pc_restore_valid,
    output logic              recovery_done,
    output logic              ckpt_valid,
    output logic              recovery_fail
);

    localparam int IDX_W = $clog2(NUM_REGS + 1);
    localparam int RC_W  = $clog2(CKPT_INTERVAL);
    localparam int RT_W  = $clog2(MAX_RETRY + 1);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REGS - 1);
    localparam logic [IDX_W-1:0] IDX_END  = IDX_W'(NUM_REGS);
    localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(CKPT_INTERVAL - 1);
    localparam logic [RT_W-1:0]  RT_MAX   = RT_W'(MAX_RETRY);

    typedef enum logic [2:0] {IDLE, COPY, RESTORE, DONE, FAIL} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q;
    logic [RC_W-1:0]   rcnt_q;
    logic [RT_W-1:0]   retry_q;
    logic              ckpt_valid_q;
    logic              act_bank_q;
    logic [DATA_W-1:0] pc_restore_q;
    logic              pc_vld_q;

    logic              ckpt_go, rec_go, copy_abort, copy_commit, retry_full, rd_issue;

    logic              rd_vld_p1;
    logic [ADDR_W-1:0] rd_addr_p1;

    logic [DATA_W-1:0] shadow_rf [2][NUM_REGS];
    logic [DATA_W-1:0] shadow_pc [2];

    assign retry_full = (retry_q == RT_MAX);

    always_comb begin
        state_d     = state_q;
        ckpt_go     = 1'b0;
        rec_go      = 1'b0;
        copy_abort  = 1'b0;
        copy_commit = 1'b0;
        case (state_q)
            IDLE: begin
                if (recover_cpu) begin
                    rec_go  = 1'b1;
                    state_d = retry_full ? FAIL : RESTORE;
                end else if (!freeze_cpu && instr_retire && rcnt_q == RC_LAST) begin
                    ckpt_go = 1'b1;
                    state_d = COPY;
                end
            end
            COPY: begin
                // Aborting leaves the active bank alone, so the previous snapshot survives.
                if (recover_cpu) begin
                    copy_abort = 1'b1;
                    rec_go     = 1'b1;
                    state_d    = retry_full ? FAIL : RESTORE;
                end else if (freeze_cpu) begin
                    copy_abort = 1'b1;
                    state_d    = IDLE;
                end else if (idx_q == IDX_END) begin
                    copy_commit = 1'b1;
                    state_d     = IDLE;
                end
            end
            RESTORE: if (idx_q == IDX_LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            FAIL:    state_d = FAIL;
            default: state_d = IDLE;
        endcase
    end

    assign rd_issue = (state_q == COPY) && !copy_abort && (idx_q < IDX_END);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            rcnt_q       <= '0;
            retry_q      <= '0;
            ckpt_valid_q <= 1'b0;
            act_bank_q   <= 1'b0;
            pc_restore_q <= RESET_PC;
            pc_vld_q     <= 1'b0;
            rd_vld_p1    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d == state_q && (state_q == COPY || state_q == RESTORE))
                idx_q <= idx_q + 1'b1;
            else
                idx_q <= '0;
            rd_vld_p1 <= rd_issue;

            if (state_q == DONE || ckpt_go)
                rcnt_q <= '0;
            else if (state_q == IDLE && instr_retire && !freeze_cpu && !recover_cpu)
                rcnt_q <= rcnt_q + 1'b1;

            if (copy_commit) begin
                retry_q      <= '0;
                ckpt_valid_q <= 1'b1;
                act_bank_q   <= ~act_bank_q;
            end else if (rec_go && !retry_full) begin
                retry_q <= retry_q + 1'b1;
            end

            if (state_q == RESTORE && state_d == DONE) begin
                pc_restore_q <= ckpt_valid_q ? shadow_pc[act_bank_q] : RESET_PC;
                pc_vld_q     <= 1'b1;
            end else if (resume_cpu) begin
                pc_vld_q <= 1'b0;
            end
        end
    end

    // p1: read data returns one cycle after the address; land it in the inactive bank
    always_ff @(posedge clk) begin
        rd_addr_p1 <= idx_q[ADDR_W-1:0];
        if (ckpt_go)
            shadow_pc[~act_bank_q] <= pc_in;
        if (rd_vld_p1)
            shadow_rf[~act_bank_q][rd_addr_p1] <= rf_rd_data;
    end

    assign cpu_stall        = (state_q == COPY);
    assign rf_rd_addr       = rd_issue ? idx_q[ADDR_W-1:0] : '0;
    assign rf_wr_en         = (state_q == RESTORE);
    assign rf_wr_addr       = rf_wr_en ? idx_q[ADDR_W-1:0] : '0;
    assign rf_wr_data       = (rf_wr_en && ckpt_valid_q) ? shadow_rf[act_bank_q][idx_q[ADDR_W-1:0]] : '0;
    assign pc_restore       = pc_restore_q;
    assign pc_restore_valid = pc_vld_q;
    assign recovery_done    = (state_q == DONE);
    assign ckpt_valid       = ckpt_valid_q;
    assign recovery_fail    = (state_q == FAIL);

endmodule

// File: tb/tb_checkpoint_rollback_ctrl.sv
// Directed bench for checkpoint_rollback_ctrl: vector table for reset/retire counting,
// hand sequences for copy, restore, aborted copy, retry exhaustion and mid-restore reset.
module tb_checkpoint_rollback_ctrl;

    localparam logic [31:0] RPC = 32'h0000_0400;

    logic        clk;
    logic        reset, freeze_cpu, recover_cpu, resume_cpu, instr_retire;
    logic [31:0] pc_in;
    logic [4:0]  rf_rd_addr;
    logic [31:0] rf_rd_data;
    logic        rf_wr_en;
    logic [4:0]  rf_wr_addr;
    logic [31:0] rf_wr_data;
    logic        cpu_stall;
    logic [31:0] pc_restore;
    logic        pc_restore_valid, recovery_done, ckpt_valid, recovery_fail;

    checkpoint_rollback_ctrl #(
        .NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .CKPT_INTERVAL(64), .MAX_RETRY(3), .RESET_PC(RPC)
    ) dut (
        .clk(clk), .reset(reset), .freeze_cpu(freeze_cpu), .recover_cpu(recover_cpu),
        .resume_cpu(resume_cpu), .instr_retire(instr_retire), .pc_in(pc_in),
        .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data), .rf_wr_en(rf_wr_en),
        .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data), .cpu_stall(cpu_stall),
        .pc_restore(pc_restore), .pc_restore_valid(pc_restore_valid),
        .recovery_done(recovery_done), .ckpt_valid(ckpt_valid), .recovery_fail(recovery_fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-file model: bench-side loads take priority over restore writes
    logic [31:0] rf [32];
    logic        tb_we;
    logic [4:0]  tb_wa;
    logic [31:0] tb_wd;
    always @(posedge clk) begin
        rf_rd_data <= rf[rf_rd_addr];
        if (tb_we) rf[tb_wa] <= tb_wd;
        else if (rf_wr_en) rf[rf_wr_addr] <= rf_wr_data;
    end

    logic [31:0] gold1 [32];
    logic [31:0] gold2 [32];
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int          reps;
        logic        rst, frz, rec, ret;
        logic [31:0] pc;
        logic        stall, ckv, wen, done, pcv, fail;
        logic [4:0]  rda;
        logic [31:0] pcr;
    } vec_t;
    vec_t vecs [6];

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic stall, input logic ckv, input logic wen,
                              input logic done, input logic pcv, input logic fail,
                              input logic [4:0] rda, input logic [31:0] pcr);
        chk({tag, ".stall"}, 32'(cpu_stall), 32'(stall));
        chk({tag, ".ckpt_valid"}, 32'(ckpt_valid), 32'(ckv));
        chk({tag, ".wr_en"}, 32'(rf_wr_en), 32'(wen));
        chk({tag, ".done"}, 32'(recovery_done), 32'(done));
        chk({tag, ".pc_valid"}, 32'(pc_restore_valid), 32'(pcv));
        chk({tag, ".fail"}, 32'(recovery_fail), 32'(fail));
        chk({tag, ".rd_addr"}, 32'(rf_rd_addr), 32'(rda));
        chk({tag, ".pc_restore"}, pc_restore, pcr);
    endtask

    task automatic load_rf(input int which);
        for (int i = 0; i < 32; i++) begin
            tb_we = 1'b1;
            tb_wa = 5'(i);
            tb_wd = (which == 1) ? gold1[i] : (which == 2) ? gold2[i] : ~gold1[i];
            tick();
        end
        tb_we = 1'b0;
    endtask

    task automatic do_recover(input string tag, input logic [31:0] exp_pc, input bit use_gold);
        recover_cpu = 1'b1;
        tick();
        recover_cpu = 1'b0;
        for (int k = 0; k < 32; k++) begin
            if (k > 0) tick();
            chk({tag, ".wr_en"}, 32'(rf_wr_en), 32'd1);
            chk({tag, ".wr_addr"}, 32'(rf_wr_addr), k);
            chk({tag, ".wr_data"}, rf_wr_data, use_gold ? gold1[k] : 32'd0);
        end
        tick();
        chk({tag, ".done"}, 32'(recovery_done), 32'd1);
        chk({tag, ".pc_valid"}, 32'(pc_restore_valid), 32'd1);
        chk({tag, ".pc_restore"}, pc_restore, exp_pc);
        chk({tag, ".wr_en_after"}, 32'(rf_wr_en), 32'd0);
        tick();
        chk({tag, ".done_pulse"}, 32'(recovery_done), 32'd0);
        tick();
        tick();
        chk({tag, ".pc_valid_hold"}, 32'(pc_restore_valid), 32'd1);
        chk({tag, ".pc_restore_hold"}, pc_restore, exp_pc);
        resume_cpu = 1'b1;
        tick();
        resume_cpu = 1'b0;
        chk({tag, ".pc_valid_clr"}, 32'(pc_restore_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad_rf;
        int done_seen;
        int fail_low;

        for (int i = 0; i < 32; i++) begin
            gold1[i] = 32'h1000_0000 + 32'(i * 3);
            gold2[i] = 32'hA5A5_0000 + 32'(i);
        end
        gold1[5] = 32'hDEAD_BEEF;

        vecs[0] = '{2,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, RPC};
        vecs[1] = '{60, 1'b0, 1'b0, 1'b0, 1'b1, 32'h40,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, RPC};
        vecs[2] = '{10, 1'b0, 1'b1, 1'b0, 1'b1, 32'h40,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, RPC};
        vecs[3] = '{3,  1'b0, 1'b0, 1'b0, 1'b0, 32'h40,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, RPC};
        vecs[4] = '{3,  1'b0, 1'b0, 1'b0, 1'b1, 32'h40,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, RPC};
        vecs[5] = '{1,  1'b0, 1'b0, 1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, RPC};

        reset = 1'b1; freeze_cpu = 1'b0; recover_cpu = 1'b0; resume_cpu = 1'b0;
        instr_retire = 1'b0; pc_in = 32'h0; tb_we = 1'b0; tb_wa = 5'd0; tb_wd = 32'h0;
        @(negedge clk);
        load_rf(1);

        // Reset state, retire counting with freeze hold, checkpoint trigger
        for (int i = 0; i < 6; i++) begin
            reset = vecs[i].rst; freeze_cpu = vecs[i].frz; recover_cpu = vecs[i].rec;
            instr_retire = vecs[i].ret; pc_in = vecs[i].pc;
            repeat (vecs[i].reps) tick();
            check_outs($sformatf("vec%0d", i), vecs[i].stall, vecs[i].ckv, vecs[i].wen,
                       vecs[i].done, vecs[i].pcv, vecs[i].fail, vecs[i].rda, vecs[i].pcr);
        end
        instr_retire = 1'b0;

        // First copy: 33 stall cycles, read addresses 0..31
        for (int k = 1; k <= 32; k++) begin
            tick();
            chk($sformatf("copy1.stall%0d", k), 32'(cpu_stall), 32'd1);
            if (k < 32) chk($sformatf("copy1.rd_addr%0d", k), 32'(rf_rd_addr), k);
        end
        tick();
        chk("copy1.stall_drop", 32'(cpu_stall), 32'd0);
        chk("copy1.ckpt_valid", 32'(ckpt_valid), 32'd1);

        // Corrupt the register file, then roll back
        load_rf(0);
        do_recover("rest1", 32'h100, 1'b1);
        bad_rf = 0;
        for (int i = 0; i < 32; i++) if (rf[i] !== gold1[i]) bad_rf++;
        chk("rest1.rf_bad_count", bad_rf, 32'd0);
        chk("rest1.rf5", rf[5], 32'hDEAD_BEEF);

        // Second copy aborted by freeze at cycle 10; rollback must return the first snapshot
        load_rf(2);
        instr_retire = 1'b1; pc_in = 32'h1c;
        repeat (63) tick();
        pc_in = 32'h200;
        tick();
        instr_retire = 1'b0;
        chk("copy2.stall_start", 32'(cpu_stall), 32'd1);
        repeat (10) tick();
        chk("copy2.stall_c10", 32'(cpu_stall), 32'd1);
        freeze_cpu = 1'b1;
        tick();
        freeze_cpu = 1'b0;
        chk("copy2.stall_abort", 32'(cpu_stall), 32'd0);
        chk("copy2.ckpt_valid", 32'(ckpt_valid), 32'd1);
        do_recover("rest2", 32'h100, 1'b1);

        // Reset in the middle of a restore
        recover_cpu = 1'b1;
        tick();
        recover_cpu = 1'b0;
        repeat (9) tick();
        chk("midrst.pre_wen", 32'(rf_wr_en), 32'd1);
        chk("midrst.pre_addr", 32'(rf_wr_addr), 32'd9);
        reset = 1'b1;
        tick();
        check_outs("midrst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, RPC);
        chk("midrst.wr_addr", 32'(rf_wr_addr), 32'd0);
        chk("midrst.wr_data", rf_wr_data, 32'd0);
        reset = 1'b0;
        tick();
        check_outs("midrst_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, RPC);

        // No checkpoint: zeros and RESET_PC; then exhaust the retry budget
        do_recover("nock1", RPC, 1'b0);
        do_recover("nock2", RPC, 1'b0);
        do_recover("nock3", RPC, 1'b0);
        recover_cpu = 1'b1;
        tick();
        recover_cpu = 1'b0;
        chk("fail.flag", 32'(recovery_fail), 32'd1);
        chk("fail.wr_en", 32'(rf_wr_en), 32'd0);
        done_seen = 0;
        fail_low = 0;
        for (int k = 0; k < 40; k++) begin
            recover_cpu = (k == 20);
            tick();
            if (recovery_done) done_seen++;
            if (!recovery_fail || rf_wr_en) fail_low++;
        end
        recover_cpu = 1'b0;
        chk("fail.done_pulses", done_seen, 32'd0);
        chk("fail.not_sticky", fail_low, 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("fail.cleared", 32'(recovery_fail), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
